booth_serial_mac_signed16: RTL



---
 rtl/booth_serial_mac_signed16.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/booth_serial_mac_signed16.sv
// Radix-4 Booth serial multiply-accumulate engine.
// Accepts one signed WIDTH x WIDTH operand pair per transaction. Each RUN cycle
// retires one Booth digit of B and adds the shifted partial-product row into a
// persistent accumulator. The result is then held in DONE until it is taken.
module booth_serial_mac_signed16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_result,
  output logic             busy
);

  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned RW     = WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               bprev_q, bprev_d;
  logic [KW-1:0]      k_q, k_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   result_q, result_d;

  // Partial-product layer signals for the current digit.
  logic               b_high, b_low, b_m1;
  logic               sel_one, sel_two, cin;
  logic [RW-1:0]      mag, row;
  logic [ACC_W-1:0]   row_ext, addend, acc_sum;
  logic [KW:0]        shamt;
  logic               last_digit;

  // B is shifted right two bits per digit, so the current digit always sits in
  // b_q[1:0] and the bit below it is carried in bprev_q (0 for the first digit).
  assign b_high = b_q[1];
  assign b_low  = b_q[0];
  assign b_m1   = bprev_q;

  // Booth digit decode and row formation: magnitude select, then inverted
  // magnitude plus cin for negative digits.
  always_comb begin
    sel_one = b_low ^ b_m1;
    sel_two = (b_high & ~b_low & ~b_m1) | (~b_high & b_low & b_m1);
    cin     = b_high & ~(b_low & b_m1);
    mag     = '0;
    if (sel_two) begin
      mag = {a_q[WIDTH-1], a_q, 1'b0};
    end else if (sel_one) begin
      mag = {{2{a_q[WIDTH-1]}}, a_q};
    end
    row     = (cin ? ~mag : mag) + {{(RW-1){1'b0}}, cin};
    row_ext = {{(ACC_W-RW){row[RW-1]}}, row};
    shamt   = {k_q, 1'b0};
    addend  = row_ext << shamt;
    acc_sum = acc_q + addend;
  end

  assign last_digit = (k_q == KW'(DIGITS - 1));

  // Next-state and datapath update for IDLE / RUN / DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    bprev_d  = bprev_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          bprev_d = 1'b0;
          k_d     = '0;
          if (!in_mac) begin
            acc_d = '0;
          end
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_sum;
        b_d     = {2'b00, b_q[WIDTH-1:2]};
        bprev_d = b_q[1];
        k_d     = k_q + KW'(1);
        if (last_digit) begin
          k_d      = '0;
          result_d = acc_sum;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      bprev_q  <= 1'b0;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bprev_q  <= bprev_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_RUN);
  assign out_result = result_q;

endmodule
